// File: rtl/uvmt_reset_st_rst_seq_pkg.sv
// Shared types and limits for the reset-VIP self-test reset sequencer.
package uvmt_reset_st_rst_seq_pkg;

  typedef enum logic [1:0] {IDLE, ASSERT, RELEASE, DONE} rst_seq_state_t;

  localparam int unsigned MAX_DOMAINS = 16;

endpackage

// File: rtl/uvmt_reset_st_rst_seq_cnt.sv
// Non-wrapping down-counter with load, decrement and zero flag; used for hold and stagger gaps.
module uvmt_reset_st_rst_seq_cnt #(
  parameter int unsigned CntW = 16
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic [CntW-1:0] load_val_i,
  input  logic            dec_i,
  output logic            zero_o
);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/uvmt_reset_st_rst_seq_ctrl.sv
// Reset sequencer: holds all domains in reset, then releases them in index order with a stagger.
// Optional statistics counters are enabled by UVMT_RESET_ST_RST_SEQ_CTRL_STATS_EN.
module uvmt_reset_st_rst_seq_ctrl
  import uvmt_reset_st_rst_seq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start_req,
  output logic                   start_ready,
  input  logic [CNT_W-1:0]       assert_cycles,
  input  logic [CNT_W-1:0]       stagger_cycles,
  input  logic                   abort,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   busy,
  output logic                   done
`ifdef UVMT_RESET_ST_RST_SEQ_CTRL_STATS_EN
  ,
  output logic [7:0]             seq_count,
  output logic [7:0]             abort_count
`endif
);

  localparam int unsigned IdxW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  if ((NUM_DOMAINS < 1) || (NUM_DOMAINS > MAX_DOMAINS)) begin : g_bad_cfg
    $error("NUM_DOMAINS out of range");
  end

  rst_seq_state_t         state_d, state_q;
  logic [NUM_DOMAINS-1:0] rst_d, rst_q;
  logic [IdxW-1:0]        idx_d, idx_q;
  logic [CNT_W-1:0]       stag_d, stag_q;
  logic                   busy_d, busy_q;
  logic                   done_d, done_q;

  logic             hold_load, hold_dec, hold_zero;
  logic [CNT_W-1:0] hold_val;
  logic             gap_load, gap_dec, gap_zero;
  logic [CNT_W-1:0] gap_val;

  always_comb begin
    state_d   = state_q;
    rst_d     = rst_q;
    idx_d     = idx_q;
    stag_d    = stag_q;
    hold_load = 1'b0;
    hold_dec  = 1'b0;
    // A hold length of 0 behaves as 1, so both load a count of 0.
    hold_val  = (assert_cycles == '0) ? '0 : (assert_cycles - CNT_W'(1));
    gap_load  = 1'b0;
    gap_dec   = 1'b0;
    gap_val   = stag_q - CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          state_d   = ASSERT;
          rst_d     = '0;
          idx_d     = '0;
          stag_d    = stagger_cycles;
          hold_load = 1'b1;
        end
      end
      ASSERT: begin
        if (abort) begin
          state_d = IDLE;
          rst_d   = '0;
        end else if (hold_zero) begin
          state_d = RELEASE;
          if (stag_q == '0) begin
            rst_d = '1;
          end else begin
            rst_d[0] = 1'b1;
            idx_d    = IdxW'(1);
            gap_load = 1'b1;
          end
        end else begin
          hold_dec = 1'b1;
        end
      end
      RELEASE: begin
        if (abort) begin
          state_d = IDLE;
          rst_d   = '0;
        end else if (rst_q[NUM_DOMAINS-1]) begin
          state_d = DONE;
        end else if (gap_zero) begin
          rst_d[idx_q] = 1'b1;
          idx_d        = idx_q + IdxW'(1);
          gap_load     = 1'b1;
        end else begin
          gap_dec = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == ASSERT) || (state_d == RELEASE);
    done_d = (state_q == RELEASE) && (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rst_q   <= '0;
      idx_q   <= '0;
      stag_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rst_q   <= rst_d;
      idx_q   <= idx_d;
      stag_q  <= stag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  uvmt_reset_st_rst_seq_cnt #(
    .CntW (CNT_W)
  ) u_hold_cnt (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (hold_load),
    .load_val_i (hold_val),
    .dec_i      (hold_dec),
    .zero_o     (hold_zero)
  );

  uvmt_reset_st_rst_seq_cnt #(
    .CntW (CNT_W)
  ) u_gap_cnt (
    .clk_i      (clk),
    .rst_ni     (reset_n),
    .load_i     (gap_load),
    .load_val_i (gap_val),
    .dec_i      (gap_dec),
    .zero_o     (gap_zero)
  );

  assign start_ready = (state_q == IDLE);
  assign rst_n_out   = rst_q;
  assign busy        = busy_q;
  assign done        = done_q;

`ifdef UVMT_RESET_ST_RST_SEQ_CTRL_STATS_EN
  logic [7:0] seq_cnt_q, abort_cnt_q;
  logic       abort_eff;

  assign abort_eff = abort && ((state_q == ASSERT) || (state_q == RELEASE));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      seq_cnt_q   <= '0;
      abort_cnt_q <= '0;
    end else begin
      if (done_d && (seq_cnt_q != 8'hFF)) begin
        seq_cnt_q <= seq_cnt_q + 8'd1;
      end
      if (abort_eff && (abort_cnt_q != 8'hFF)) begin
        abort_cnt_q <= abort_cnt_q + 8'd1;
      end
    end
  end

  assign seq_count   = seq_cnt_q;
  assign abort_count = abort_cnt_q;
`endif

endmodule

// File: tb/tb_uvmt_reset_st_rst_seq_ctrl.sv
// Self-checking bench for uvmt_reset_st_rst_seq_ctrl: timing-formula model plus literal checks.
// Stats checks are compiled in when UVMT_RESET_ST_RST_SEQ_CTRL_STATS_EN is defined.
module tb_uvmt_reset_st_rst_seq_ctrl;

  localparam int N = 4;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start_req = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] assert_cycles = '0;
  logic [W-1:0] stagger_cycles = '0;
  logic         start_ready, busy, done;
  logic [N-1:0] rst_n_out;
`ifdef UVMT_RESET_ST_RST_SEQ_CTRL_STATS_EN
  logic [7:0]   seq_count, abort_count;
`endif

  always #5 clk = ~clk;

  uvmt_reset_st_rst_seq_ctrl #(
    .NUM_DOMAINS (N),
    .CNT_W       (W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_req      (start_req),
    .start_ready    (start_ready),
    .assert_cycles  (assert_cycles),
    .stagger_cycles (stagger_cycles),
    .abort          (abort),
    .rst_n_out      (rst_n_out),
    .busy           (busy),
    .done           (done)
`ifdef UVMT_RESET_ST_RST_SEQ_CTRL_STATS_EN
    ,
    .seq_count      (seq_count),
    .abort_count    (abort_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;

  // Model: one sequence described by accept edge, hold length and stagger; timing is pure arithmetic.
  bit m_valid = 1'b0;
  bit m_seq_on = 1'b0;
  int m_t = 0;
  int m_a = 1;
  int m_s = 0;
  int m_seq = 0;
  int m_ab = 0;

  function automatic int f_last();
    return m_t + m_a + (N - 1) * m_s;
  endfunction

  function automatic logic f_busy(int e);
    return m_seq_on && (e <= f_last());
  endfunction

  function automatic logic f_done(int e);
    return m_seq_on && (e == f_last() + 1);
  endfunction

  function automatic logic f_ready(int e);
    return !m_seq_on || (e >= f_last() + 2);
  endfunction

  function automatic logic [N-1:0] f_rst(int e);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = m_seq_on && (e >= m_t + m_a + i * m_s);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, want %0h", name, edge_n + 1, got, exp);
    end
  endtask

  always @(posedge clk) begin
    logic pre_ready, pre_busy;
    pre_ready = f_ready(edge_n);
    pre_busy  = f_busy(edge_n);
    edge_n++;
    if (!reset_n) begin
      m_valid  = 1'b1;
      m_seq_on = 1'b0;
      m_seq    = 0;
      m_ab     = 0;
    end else if (m_valid) begin
      if (start_req && pre_ready) begin
        m_seq_on = 1'b1;
        m_t      = edge_n;
        m_a      = (assert_cycles == '0) ? 1 : int'(assert_cycles);
        m_s      = int'(stagger_cycles);
      end else if (abort && pre_busy) begin
        m_seq_on = 1'b0;
        if (m_ab < 255) m_ab++;
      end
      if (f_done(edge_n) && (m_seq < 255)) m_seq++;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("rst_n_out", 32'(rst_n_out), 32'(f_rst(edge_n)));
      chk("busy", 32'(busy), 32'(f_busy(edge_n)));
      chk("done", 32'(done), 32'(f_done(edge_n)));
      chk("start_ready", 32'(start_ready), 32'(f_ready(edge_n)));
`ifdef UVMT_RESET_ST_RST_SEQ_CTRL_STATS_EN
      chk("seq_count", 32'(seq_count), 32'(m_seq));
      chk("abort_count", 32'(abort_count), 32'(m_ab));
`endif
    end
  end

  // Cycle k is the interval after rising edge k-1; inputs driven here are sampled at edge k.
  task automatic goto_cycle(input int k);
    while (edge_n < k - 1) @(negedge clk);
  endtask

  task automatic request(input int c, input int a, input int s);
    goto_cycle(c);
    start_req      = 1'b1;
    assert_cycles  = W'(a);
    stagger_cycles = W'(s);
    goto_cycle(c + 1);
    start_req = 1'b0;
  endtask

  typedef struct {int a; int s;} cfg_t;
  cfg_t tbl[4] = '{'{1, 0}, '{1, 1}, '{3, 2}, '{2, 9}};

  initial begin
    int c;
    goto_cycle(4);
    reset_n = 1'b1;
    chk("lit reset rst_n_out", 32'(rst_n_out), 32'h0);
    chk("lit reset start_ready", 32'(start_ready), 32'h1);
    chk("lit reset busy", 32'(busy), 32'h0);

    // Accept at edge 10, A=16, S=4.
    request(10, 16, 4);
    chk("lit c11 busy", 32'(busy), 32'h1);
    goto_cycle(26); chk("lit c26 rst", 32'(rst_n_out), 32'h0);
    goto_cycle(27); chk("lit c27 rst", 32'(rst_n_out), 32'h1);
    goto_cycle(31); chk("lit c31 rst", 32'(rst_n_out), 32'h3);
    goto_cycle(35); chk("lit c35 rst", 32'(rst_n_out), 32'h7);
    goto_cycle(39); chk("lit c39 rst", 32'(rst_n_out), 32'hF);
    goto_cycle(40);
    chk("lit c40 done", 32'(done), 32'h1);
    chk("lit c40 busy", 32'(busy), 32'h0);
    goto_cycle(41);
    chk("lit c41 ready", 32'(start_ready), 32'h1);
    chk("lit c41 done", 32'(done), 32'h0);

    // A=0 behaves as 1, S=0 releases everything together.
    request(50, 0, 0);
    chk("lit c51 rst reassert", 32'(rst_n_out), 32'h0);
    goto_cycle(52); chk("lit c52 rst", 32'(rst_n_out), 32'hF);
    goto_cycle(53); chk("lit c53 done", 32'(done), 32'h1);

    // Abort mid-RELEASE, immediate re-request.
    request(60, 16, 4);
    goto_cycle(83);
    chk("lit c83 rst", 32'(rst_n_out), 32'h3);
    abort = 1'b1;
    goto_cycle(84);
    abort = 1'b0;
    chk("lit abort rst", 32'(rst_n_out), 32'h0);
    chk("lit abort busy", 32'(busy), 32'h0);
    chk("lit abort ready", 32'(start_ready), 32'h1);
    request(84, 2, 1);
    chk("lit re-accept busy", 32'(busy), 32'h1);

    // start_req held through a whole sequence; config changes while busy are ignored.
    goto_cycle(100);
    start_req = 1'b1; assert_cycles = 16; stagger_cycles = 4;
    goto_cycle(102);
    assert_cycles = 5; stagger_cycles = 0;
    goto_cycle(130); chk("lit held done", 32'(done), 32'h1);
    goto_cycle(131);
    chk("lit held ready", 32'(start_ready), 32'h1);
    chk("lit held rst", 32'(rst_n_out), 32'hF);
    goto_cycle(132);
    start_req = 1'b0;
    chk("lit 2nd accept rst", 32'(rst_n_out), 32'h0);
    chk("lit 2nd accept busy", 32'(busy), 32'h1);

    // reset_n pulse mid-RELEASE.
    request(170, 4, 3);
    goto_cycle(179);
    chk("lit pre-reset rst", 32'(rst_n_out), 32'h3);
    reset_n = 1'b0;
    goto_cycle(180);
    reset_n = 1'b1;
    chk("lit mid reset rst", 32'(rst_n_out), 32'h0);
    chk("lit mid reset ready", 32'(start_ready), 32'h1);

    // abort with start_req in IDLE: request wins; abort in DONE and IDLE is ignored.
    goto_cycle(185);
    abort = 1'b1; start_req = 1'b1; assert_cycles = 1; stagger_cycles = 1;
    goto_cycle(186);
    abort = 1'b0; start_req = 1'b0;
    chk("lit abort+req busy", 32'(busy), 32'h1);
    goto_cycle(191);
    chk("lit c191 done", 32'(done), 32'h1);
    abort = 1'b1;
    goto_cycle(193);
    abort = 1'b0;
    goto_cycle(194);
    chk("lit idle abort rst", 32'(rst_n_out), 32'hF);

    c = 200;
    foreach (tbl[i]) begin
      request(c, tbl[i].a, tbl[i].s);
      c += ((tbl[i].a == 0) ? 1 : tbl[i].a) + (N - 1) * tbl[i].s + 4;
    end

`ifdef UVMT_RESET_ST_RST_SEQ_CTRL_STATS_EN
    goto_cycle(c);
    start_req = 1'b1; assert_cycles = 1; stagger_cycles = 0;
    goto_cycle(c + 1250);
    start_req = 1'b0;
    goto_cycle(c + 1260);
    chk("lit seq_count sat", 32'(seq_count), 32'hFF);
    c += 1260;
`endif

    goto_cycle(c + 5);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
